// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core with register file, ALU, branch unit and load/store lanes
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] mem [0:31];
    assign rdata1 = raddr1 == 5'd0 ? 32'd0 : mem[raddr1];
    assign rdata2 = raddr2 == 5'd0 ? 32'd0 : mem[raddr2];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

module rv32i_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] insnmem_addr,
    input  logic [31:0] insnmem_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata_raw,
    output logic        mem_read_req,
    output logic        mem_write_req,
    output logic [3:0]  mem_byte_en
);
    logic [31:0] cur_pc, insn, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_y, load_v, wb, next_pc;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opi, is_op;
    logic        taken, we;

    assign insn         = insnmem_data;
    assign insnmem_addr = cur_pc;
    assign opcode       = insn[6:0];
    assign f3           = insn[14:12];
    assign is_lui   = opcode == 7'h37;
    assign is_auipc = opcode == 7'h17;
    assign is_jal   = opcode == 7'h6f;
    assign is_jalr  = opcode == 7'h67;
    assign is_br    = opcode == 7'h63;
    assign is_load  = opcode == 7'h03;
    assign is_store = opcode == 7'h23;
    assign is_opi   = opcode == 7'h13;
    assign is_op    = opcode == 7'h33;

    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'b0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    rv32i_regfile u_regfiles (
        .clk(clk), .rst(rst), .we(we), .waddr(insn[11:7]), .wdata(wb),
        .raddr1(insn[19:15]), .raddr2(insn[24:20]), .rdata1(rs1_v), .rdata2(rs2_v)
    );

    assign alu_b = is_op ? rs2_v : imm_i;
    always_comb begin
        alu_y = '0;
        case (f3)
            3'd0: alu_y = (is_op && insn[30]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'd1: alu_y = rs1_v << alu_b[4:0];
            3'd2: alu_y = {31'd0, $signed(rs1_v) < $signed(alu_b)};
            3'd3: alu_y = {31'd0, rs1_v < alu_b};
            3'd4: alu_y = rs1_v ^ alu_b;
            3'd5: alu_y = insn[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'd6: alu_y = rs1_v | alu_b;
            3'd7: alu_y = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'd0: taken = rs1_v == rs2_v;
            3'd1: taken = rs1_v != rs2_v;
            3'd4: taken = $signed(rs1_v) < $signed(rs2_v);
            3'd5: taken = $signed(rs1_v) >= $signed(rs2_v);
            3'd6: taken = rs1_v < rs2_v;
            3'd7: taken = rs1_v >= rs2_v;
            default: taken = 1'b0;
        endcase
    end

    // Lane selection works on the raw aligned word; misaligned low bits are simply dropped.
    assign mem_addr      = is_load ? rs1_v + imm_i : is_store ? rs1_v + imm_s : 32'd0;
    assign mem_read_req  = is_load && !rst;
    assign mem_write_req = is_store && !rst;
    assign mem_wdata     = f3[1:0] == 2'd0 ? {4{rs2_v[7:0]}} : f3[1:0] == 2'd1 ? {2{rs2_v[15:0]}} : rs2_v;
    assign mem_byte_en   = !mem_write_req ? 4'b0000 :
                           f3[1:0] == 2'd0 ? 4'b0001 << mem_addr[1:0] :
                           f3[1:0] == 2'd1 ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign byte_v = 8'(mem_rdata_raw >> {mem_addr[1:0], 3'b000});
    assign half_v = mem_addr[1] ? mem_rdata_raw[31:16] : mem_rdata_raw[15:0];
    assign load_v = f3 == 3'd0 ? {{24{byte_v[7]}}, byte_v} :
                    f3 == 3'd1 ? {{16{half_v[15]}}, half_v} :
                    f3 == 3'd4 ? {24'd0, byte_v} :
                    f3 == 3'd5 ? {16'd0, half_v} : mem_rdata_raw;

    assign wb = is_lui ? imm_u : is_auipc ? cur_pc + imm_u :
                (is_jal || is_jalr) ? cur_pc + 32'd4 : is_load ? load_v : alu_y;
    assign we = !rst && (is_lui || is_auipc || is_jal || is_jalr || is_load || is_opi || is_op);

    assign next_pc = is_jal ? cur_pc + imm_j :
                     is_jalr ? (rs1_v + imm_i) & ~32'd1 :
                     (is_br && taken) ? cur_pc + imm_b : cur_pc + 32'd4;

    always_ff @(posedge clk) begin
        cur_pc <= rst ? RESET_PC : next_pc;
    end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs with hand-computed register, PC and bus expectations
module tb_rv32i_core;
    logic        clk, rst;
    logic [31:0] insnmem_addr, insnmem_data, mem_addr, mem_wdata, mem_rdata_raw;
    logic        mem_read_req, mem_write_req;
    logic [3:0]  mem_byte_en;
    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:255];
    int total = 0, bad = 0;

    rv32i_core dut (
        .clk(clk), .rst(rst), .insnmem_addr(insnmem_addr), .insnmem_data(insnmem_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata_raw(mem_rdata_raw),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_byte_en(mem_byte_en)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    assign insnmem_data  = imem[insnmem_addr[7:2]];
    assign mem_rdata_raw = dmem[mem_addr[9:2]];
    always @(posedge clk)
        if (mem_write_req)
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) dmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] xr(input int n);
        return dut.u_regfiles.mem[n];
    endfunction

    function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction
    function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic clear_imem;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic do_reset;
        rst = 1;
        step(1);
        chk("rst_pc", dut.cur_pc, 32'h0);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_imem();
        imem[0] = s_t(0, 0, 0, 3'd2);
        step(2);
        chk("rst_pc0", dut.cur_pc, 32'h0);
        chk("rst_wreq", {31'd0, mem_write_req}, 32'h0);
        chk("rst_ben", {28'd0, mem_byte_en}, 32'h0);
        chk("rst_x1", xr(1), 32'h0);
        rst = 0;
        #1;
        chk("run_wreq", {31'd0, mem_write_req}, 32'h1);
        chk("run_ben", {28'd0, mem_byte_en}, 32'hf);
        step(1); chk("pc4", dut.cur_pc, 32'h4);
        step(1); chk("pc8", dut.cur_pc, 32'h8);
        step(1); chk("pc12", dut.cur_pc, 32'hc);

        clear_imem();
        imem[0] = i_t(-1, 0, 3'd0, 1, 7'h13);
        imem[1] = i_t(32'h404, 1, 3'd5, 2, 7'h13);
        imem[2] = i_t(28, 1, 3'd5, 3, 7'h13);
        imem[3] = r_t(7'h00, 1, 0, 3'd3, 4);
        imem[4] = i_t(5, 0, 3'd0, 0, 7'h13);
        imem[5] = u_t(32'h12345, 5, 7'h37);
        imem[6] = r_t(7'h20, 1, 5, 3'd0, 6);
        imem[7] = r_t(7'h00, 0, 1, 3'd2, 7);
        imem[8] = i_t(-1, 5, 3'd4, 8, 7'h13);
        imem[9] = r_t(7'h00, 3, 4, 3'd1, 9);
        do_reset();
        step(10);
        chk("addi_x1", xr(1), 32'hffffffff);
        chk("srai_x2", xr(2), 32'hffffffff);
        chk("srli_x3", xr(3), 32'h0000000f);
        chk("sltu_x4", xr(4), 32'h1);
        chk("x0_zero", xr(0), 32'h0);
        chk("lui_x5", xr(5), 32'h12345000);
        chk("sub_x6", xr(6), 32'h12345001);
        chk("slt_x7", xr(7), 32'h1);
        chk("xori_x8", xr(8), 32'hedcbafff);
        chk("sll_x9", xr(9), 32'h00008000);
        chk("alu_pc", dut.cur_pc, 32'd40);

        clear_imem();
        imem[4]  = u_t(1, 10, 7'h17);
        imem[8]  = j_t(8, 1);
        imem[9]  = i_t(7, 0, 3'd0, 11, 7'h13);
        imem[10] = i_t(1, 1, 3'd0, 0, 7'h67);
        do_reset();
        step(5);
        chk("auipc_x10", xr(10), 32'h1010);
        step(4);
        chk("jal_pc", dut.cur_pc, 32'h28);
        chk("jal_x1", xr(1), 32'h24);
        step(1);
        chk("jalr_pc", dut.cur_pc, 32'h24);
        step(1);
        chk("after_jalr_x11", xr(11), 32'h7);
        chk("after_jalr_pc", dut.cur_pc, 32'h28);

        clear_imem();
        imem[0]  = u_t(32'h80ff8, 1, 7'h37);
        imem[1]  = i_t(-255, 1, 3'd0, 1, 7'h13);
        imem[2]  = i_t(32'h100, 0, 3'd0, 2, 7'h13);
        imem[3]  = s_t(0, 1, 2, 3'd2);
        imem[4]  = i_t(0, 2, 3'd0, 3, 7'h03);
        imem[5]  = i_t(3, 2, 3'd0, 4, 7'h03);
        imem[6]  = i_t(3, 2, 3'd4, 5, 7'h03);
        imem[7]  = i_t(2, 2, 3'd1, 6, 7'h03);
        imem[8]  = i_t(2, 2, 3'd5, 7, 7'h03);
        imem[9]  = i_t(0, 2, 3'd2, 8, 7'h03);
        imem[10] = s_t(3, 3, 2, 3'd0);
        imem[11] = s_t(2, 1, 2, 3'd1);
        imem[12] = i_t(0, 2, 3'd2, 9, 7'h03);
        do_reset();
        step(3);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_wdata", mem_wdata, 32'h80ff7f01);
        chk("sw_ben", {28'd0, mem_byte_en}, 32'hf);
        chk("sw_rreq", {31'd0, mem_read_req}, 32'h0);
        step(1);
        chk("lb_rreq", {31'd0, mem_read_req}, 32'h1);
        chk("lb_wreq", {31'd0, mem_write_req}, 32'h0);
        chk("lb_ben", {28'd0, mem_byte_en}, 32'h0);
        step(6);
        chk("sb_addr", mem_addr, 32'h103);
        chk("sb_ben", {28'd0, mem_byte_en}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'h01010101);
        step(1);
        chk("sh_ben", {28'd0, mem_byte_en}, 32'hc);
        chk("sh_wdata", mem_wdata, 32'h7f017f01);
        step(2);
        chk("lb_x3", xr(3), 32'h00000001);
        chk("lb_x4", xr(4), 32'hffffff80);
        chk("lbu_x5", xr(5), 32'h00000080);
        chk("lh_x6", xr(6), 32'hffff80ff);
        chk("lhu_x7", xr(7), 32'h000080ff);
        chk("lw_x8", xr(8), 32'h80ff7f01);
        chk("lw_x9", xr(9), 32'h7f017f01);

        clear_imem();
        imem[0] = i_t(-1, 0, 3'd0, 1, 7'h13);
        imem[1] = i_t(1, 0, 3'd0, 2, 7'h13);
        imem[2] = b_t(8, 2, 1, 3'd4);
        imem[3] = i_t(99, 0, 3'd0, 3, 7'h13);
        imem[4] = b_t(8, 2, 1, 3'd6);
        imem[5] = i_t(5, 0, 3'd0, 4, 7'h13);
        imem[6] = b_t(8, 2, 1, 3'd5);
        imem[7] = b_t(8, 2, 1, 3'd7);
        imem[8] = i_t(98, 0, 3'd0, 3, 7'h13);
        imem[9] = b_t(-8, 0, 0, 3'd0);
        do_reset();
        step(3);
        chk("blt_pc", dut.cur_pc, 32'd16);
        step(1);
        chk("bltu_pc", dut.cur_pc, 32'd20);
        step(2);
        chk("bge_pc", dut.cur_pc, 32'd28);
        step(1);
        chk("bgeu_pc", dut.cur_pc, 32'd36);
        step(1);
        chk("beq_pc", dut.cur_pc, 32'd28);
        chk("br_x3", xr(3), 32'h0);
        chk("br_x4", xr(4), 32'h5);

        clear_imem();
        imem[0] = i_t(0, 0, 3'd0, 1, 7'h13);
        imem[1] = i_t(200, 0, 3'd0, 2, 7'h13);
        imem[2] = i_t(1, 1, 3'd0, 1, 7'h13);
        imem[3] = 32'h0;
        imem[4] = b_t(-8, 2, 1, 3'd1);
        imem[5] = j_t(0, 0);
        do_reset();
        step(800);
        chk("loop_pc", dut.cur_pc, 32'd20);
        chk("loop_x1", xr(1), 32'd200);
        chk("loop_x2", xr(2), 32'd200);
        chk("loop_x0", xr(0), 32'h0);
        do_reset();
        chk("midrst_x1", xr(1), 32'h0);
        chk("midrst_x2", xr(2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
